// File: rtl/pe_operand_feeder_if.sv
// Upstream pair stream into the PE operand feeder: valid/ready handshake
// carrying one (weight, activation, last) pair per transfer.
interface pe_operand_feeder_if;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_weight;
  logic [7:0] i_activation;
  logic       i_last;

  modport master (output i_valid, i_weight, i_activation, i_last, input o_ready);
  modport slave  (input i_valid, i_weight, i_activation, i_last, output o_ready);
endinterface

// File: rtl/pe_operand_feeder.sv
// Sparsity-skipping operand issue front end: buffers pairs, drops zero pairs,
// and brackets each vector with a clear pulse and a pipeline-aligned done pulse.
module pe_operand_feeder #(
  parameter int DEPTH     = 4,
  parameter int DRAIN_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  pe_operand_feeder_if.slave  up,
  input  logic                i_stall,
  output logic [3:0]          o_weight,
  output logic [7:0]          o_activation,
  output logic                o_issue,
  output logic                o_clear,
  output logic                o_done,
  output logic [15:0]         o_issue_count,
  output logic [15:0]         o_skip_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DRAIN_LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic       last;
    logic [3:0] weight;
    logic [7:0] activation;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_q, count_d;
  logic           ready_q, ready_d;
  state_t         state_q, state_d;
  logic [DW-1:0]  drain_q, drain_d;

  logic           push, pop, empty, head_zero;
  entry_t         head;
  logic           clear_d, done_d, issue_d;
  logic [3:0]     weight_d;
  logic [7:0]     act_d;
  logic [15:0]    issue_cnt_d, skip_cnt_d;

  assign up.o_ready = ready_q;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    push        = up.i_valid && ready_q;
    empty       = (count_q == '0);
    head        = mem[rd_ptr];
    head_zero   = (head.weight == '0) || (head.activation == '0);
    state_d     = state_q;
    drain_d     = drain_q;
    pop         = 1'b0;
    clear_d     = 1'b0;
    done_d      = 1'b0;
    issue_d     = 1'b0;
    weight_d    = '0;
    act_d       = '0;
    issue_cnt_d = o_issue_count;
    skip_cnt_d  = o_skip_count;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          clear_d     = 1'b1;
          issue_cnt_d = '0;
          skip_cnt_d  = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (!empty && !i_stall) begin
          pop = 1'b1;
          if (!head_zero) begin
            issue_d  = 1'b1;
            weight_d = head.weight;
            act_d    = head.activation;
            if (o_issue_count != 16'hFFFF) issue_cnt_d = o_issue_count + 16'd1;
          end else if (o_skip_count != 16'hFFFF) begin
            skip_cnt_d = o_skip_count + 16'd1;
          end
          if (head.last) begin
            state_d = DRAIN;
            drain_d = DW'(DRAIN_LAT);
          end
        end
      end
      DRAIN: begin
        // Outputs stay 0/0 while the PE shifter and accumulator registers settle.
        if (drain_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CW'(DEPTH));
  end

  // NOTE: the FIFO storage has no reset; the pointers and occupancy count
  // define which entries are meaningful, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{last: up.i_last, weight: up.i_weight, activation: up.i_activation};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      drain_q       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      ready_q       <= 1'b1;
      o_weight      <= '0;
      o_activation  <= '0;
      o_issue       <= 1'b0;
      o_clear       <= 1'b0;
      o_done        <= 1'b0;
      o_issue_count <= '0;
      o_skip_count  <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      o_weight      <= weight_d;
      o_activation  <= act_d;
      o_issue       <= issue_d;
      o_clear       <= clear_d;
      o_done        <= done_d;
      o_issue_count <= issue_cnt_d;
      o_skip_count  <= skip_cnt_d;
    end
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder: hand-computed cycle tables for the
// basic, sparse and all-zero vectors, plus backpressure, streaming and reset.
module tb_pe_operand_feeder;
  localparam int DEPTH     = 4;
  localparam int DRAIN_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_stall;
  logic [3:0]  o_weight;
  logic [7:0]  o_activation;
  logic        o_issue, o_clear, o_done;
  logic [15:0] o_issue_count, o_skip_count;

  int n_pass  = 0;
  int n_total = 0;

  pe_operand_feeder_if up ();

  pe_operand_feeder #(.DEPTH(DEPTH), .DRAIN_LAT(DRAIN_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .up           (up),
    .i_stall      (i_stall),
    .o_weight     (o_weight),
    .o_activation (o_activation),
    .o_issue      (o_issue),
    .o_clear      (o_clear),
    .o_done       (o_done),
    .o_issue_count(o_issue_count),
    .o_skip_count (o_skip_count)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {o_clear, o_issue, o_done, o_weight, o_activation};

  function automatic logic [14:0] ev(logic c, logic i, logic d, logic [3:0] w, logic [7:0] a);
    return {c, i, d, w, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [3:0] w, logic [7:0] a, logic l);
    up.i_valid      = v;
    up.i_weight     = w;
    up.i_activation = a;
    up.i_last       = l;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    i_stall = 1'b0;
    drive(1'b0, 4'd0, 8'd0, 1'b0);
    tick();
    tick();
    n_total++;
    if (obs !== 15'd0) $display("FAIL reset_outputs: got %h want 0", obs); else n_pass++;
    n_total++;
    if ({o_issue_count, o_skip_count} !== 32'd0)
      $display("FAIL reset_counts: got %h want 0", {o_issue_count, o_skip_count}); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++;
    if (up.o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", up.o_ready); else n_pass++;
  endtask

  task automatic test_basic(string tag);
    logic [3:0]  w [3] = '{4'd3, 4'd5, 4'd1};
    logic [7:0]  a [3] = '{8'd10, 8'd2, 8'd255};
    logic [14:0] exp [8];
    exp = '{ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), ev(1'b1, 1'b0, 1'b0, 4'd0, 8'd0),
            ev(1'b0, 1'b1, 1'b0, 4'd3, 8'd10), ev(1'b0, 1'b1, 1'b0, 4'd5, 8'd2),
            ev(1'b0, 1'b1, 1'b0, 4'd1, 8'd255), ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0),
            ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), ev(1'b0, 1'b0, 1'b1, 4'd0, 8'd0)};
    for (int c = 0; c < 8; c++) begin
      if (c < 3) drive(1'b1, w[c], a[c], c == 2); else drive(1'b0, 4'd0, 8'd0, 1'b0);
      tick();
      n_total++;
      if (obs !== exp[c]) $display("FAIL %s_cycle%0d: got %h want %h", tag, c + 1, obs, exp[c]);
      else n_pass++;
    end
    n_total++;
    if ({o_issue_count, o_skip_count} !== {16'd3, 16'd0})
      $display("FAIL %s_counts: got %0d/%0d want 3/0", tag, o_issue_count, o_skip_count);
    else n_pass++;
  endtask

  task automatic test_sparsity();
    logic [3:0]  w [3] = '{4'd0, 4'd4, 4'd2};
    logic [7:0]  a [3] = '{8'd7, 8'd0, 8'd9};
    logic [14:0] exp [8];
    exp = '{ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), ev(1'b1, 1'b0, 1'b0, 4'd0, 8'd0),
            ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0),
            ev(1'b0, 1'b1, 1'b0, 4'd2, 8'd9), ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0),
            ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), ev(1'b0, 1'b0, 1'b1, 4'd0, 8'd0)};
    n_total++;
    if ({o_issue_count, o_skip_count} !== {16'd3, 16'd0})
      $display("FAIL counts_held: got %0d/%0d want 3/0", o_issue_count, o_skip_count);
    else n_pass++;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) drive(1'b1, w[c], a[c], c == 2); else drive(1'b0, 4'd0, 8'd0, 1'b0);
      tick();
      n_total++;
      if (obs !== exp[c]) $display("FAIL sparse_cycle%0d: got %h want %h", c + 1, obs, exp[c]);
      else n_pass++;
      if (c == 1) begin
        n_total++;
        if ({o_issue_count, o_skip_count} !== 32'd0)
          $display("FAIL counts_cleared: got %0d/%0d want 0/0", o_issue_count, o_skip_count);
        else n_pass++;
      end
    end
    n_total++;
    if ({o_issue_count, o_skip_count} !== {16'd1, 16'd2})
      $display("FAIL sparse_counts: got %0d/%0d want 1/2", o_issue_count, o_skip_count);
    else n_pass++;
  endtask

  task automatic test_all_zero();
    logic [14:0] exp [6];
    exp = '{ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), ev(1'b1, 1'b0, 1'b0, 4'd0, 8'd0),
            ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0),
            ev(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), ev(1'b0, 1'b0, 1'b1, 4'd0, 8'd0)};
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(1'b1, 4'd0, 8'd0, 1'b1); else drive(1'b0, 4'd0, 8'd0, 1'b0);
      tick();
      n_total++;
      if (obs !== exp[c]) $display("FAIL zero_cycle%0d: got %h want %h", c + 1, obs, exp[c]);
      else n_pass++;
    end
    n_total++;
    if ({o_issue_count, o_skip_count} !== {16'd0, 16'd1})
      $display("FAIL zero_counts: got %0d/%0d want 0/1", o_issue_count, o_skip_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3:0]  bw [6];
    logic [7:0]  ba [6];
    logic [11:0] got [$];
    int  sent = 0, clears = 0, issues = 0;
    logic acc, done_seen;
    for (int k = 0; k < 6; k++) begin
      bw[k] = 4'(k + 1);
      ba[k] = 8'(17 * (k + 1));
    end
    i_stall = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (sent < 6) drive(1'b1, bw[sent], ba[sent], sent == 5); else drive(1'b0, 4'd0, 8'd0, 1'b0);
      acc = up.i_valid && up.o_ready;
      tick();
      if (acc) sent++;
      if (o_clear) clears++;
      if (o_issue) issues++;
    end
    n_total++;
    if (sent !== 4) $display("FAIL bp_accepts: got %0d want %0d", sent, DEPTH); else n_pass++;
    n_total++;
    if (up.o_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", up.o_ready); else n_pass++;
    n_total++;
    if (issues !== 0 || clears !== 1)
      $display("FAIL bp_stalled: got issues=%0d clears=%0d want 0/1", issues, clears);
    else n_pass++;
    i_stall   = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (sent < 6) drive(1'b1, bw[sent], ba[sent], sent == 5); else drive(1'b0, 4'd0, 8'd0, 1'b0);
      acc = up.i_valid && up.o_ready;
      tick();
      if (acc) sent++;
      if (o_issue) got.push_back({o_weight, o_activation});
      if (o_done) done_seen = 1'b1;
    end
    n_total++;
    if (done_seen !== 1'b1 || got.size() != 6)
      $display("FAIL bp_drain: got done=%b issued=%0d want 1/6", done_seen, got.size());
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (got[k] !== {bw[k], ba[k]}) $display("FAIL bp_order%0d: got %h want %h", k, got[k], {bw[k], ba[k]});
      else n_pass++;
    end
    n_total++;
    if (o_issue_count !== 16'd6) $display("FAIL bp_count: got %0d want 6", o_issue_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sw [15];
    logic [7:0]  sa [15];
    logic        sl [15];
    logic [11:0] exp_q [$];
    logic [11:0] got [$];
    int          clr_cyc [$];
    int          done_cyc [$];
    logic [31:0] done_cnt [$];
    logic [31:0] want_cnt [3] = '{{16'd5, 16'd0}, {16'd4, 16'd1}, {16'd3, 16'd2}};
    int   sent = 0;
    logic acc;
    for (int i = 0; i < 15; i++) begin
      sw[i] = 4'(1 + (i % 15));
      sa[i] = 8'(20 * (i / 5) + (i % 5) + 1);
      sl[i] = (i % 5) == 4;
    end
    sw[7]  = 4'd0;
    sa[11] = 8'd0;
    sw[13] = 4'd0;
    for (int i = 0; i < 15; i++)
      if (sw[i] != 4'd0 && sa[i] != 8'd0) exp_q.push_back({sw[i], sa[i]});
    i_stall = 1'b0;
    for (int c = 1; c <= 120 && done_cyc.size() < 3; c++) begin
      if (sent < 15) drive(1'b1, sw[sent], sa[sent], sl[sent]); else drive(1'b0, 4'd0, 8'd0, 1'b0);
      acc = up.i_valid && up.o_ready;
      tick();
      if (acc) sent++;
      if (o_clear) clr_cyc.push_back(c);
      if (o_issue) got.push_back({o_weight, o_activation});
      if (o_done) begin
        done_cyc.push_back(c);
        done_cnt.push_back({o_issue_count, o_skip_count});
      end
    end
    n_total++;
    if (clr_cyc.size() != 3 || done_cyc.size() != 3)
      $display("FAIL b2b_events: got clears=%0d dones=%0d want 3/3", clr_cyc.size(), done_cyc.size());
    else n_pass++;
    n_total++;
    if (clr_cyc[0] !== 2) $display("FAIL b2b_first_clear: got cycle %0d want 2", clr_cyc[0]); else n_pass++;
    for (int v = 0; v < 3; v++) begin
      n_total++;
      if (done_cnt[v] !== want_cnt[v])
        $display("FAIL b2b_counts%0d: got %h want %h", v, done_cnt[v], want_cnt[v]);
      else n_pass++;
    end
    for (int v = 0; v < 2; v++) begin
      n_total++;
      if (clr_cyc[v + 1] !== done_cyc[v] + 1)
        $display("FAIL b2b_clear_after_done%0d: got cycle %0d want %0d", v, clr_cyc[v + 1], done_cyc[v] + 1);
      else n_pass++;
    end
    n_total++;
    if (got.size() != exp_q.size())
      $display("FAIL b2b_issued: got %0d want %0d", got.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_total++;
      if (got[k] !== exp_q[k]) $display("FAIL b2b_order%0d: got %h want %h", k, got[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int activity = 0;
    i_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'(k + 1), 8'(k + 1), 1'b0);
      tick();
    end
    n_total++;
    if (up.o_ready !== 1'b0) $display("FAIL mid_full: got ready=%b want 0", up.o_ready); else n_pass++;
    drive(1'b0, 4'd0, 8'd0, 1'b0);
    i_stall = 1'b0;
    tick();
    n_total++;
    if (obs !== ev(1'b0, 1'b1, 1'b0, 4'd1, 8'd1) || up.o_ready !== 1'b1)
      $display("FAIL mid_first_issue: got %h ready=%b want %h ready=1", obs, up.o_ready,
               ev(1'b0, 1'b1, 1'b0, 4'd1, 8'd1));
    else n_pass++;
    reset = 1'b1;
    tick();
    n_total++;
    if (obs !== 15'd0 || {o_issue_count, o_skip_count} !== 32'd0 || up.o_ready !== 1'b1)
      $display("FAIL mid_reset: got %h cnt=%h ready=%b want 0 0 1", obs,
               {o_issue_count, o_skip_count}, up.o_ready);
    else n_pass++;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_issue || o_clear || o_done) activity++;
    end
    n_total++;
    if (activity !== 0) $display("FAIL mid_quiet: got %0d active cycles want 0", activity); else n_pass++;
    test_basic("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic("basic");
    test_sparsity();
    test_all_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
